ram64_arbiter: RTL and testbench

Two-port arbiter and sequencer for a single RAM64 (64 × 16-bit, combinational read, write on clock edge when `load` is high). It shares the memory between requesters A and B with round-robin priority and a req/ack handshake. After reset it zero-fills all 64 words, since RAM64 itself has no reset. It sits between the RAM64 instance and its two clients, driving RAM64's `in`/`load`/`address` and sampling its `out`.

---
 rtl/ram64_arbiter_pkg.sv | 16 +
 rtl/ram64_arbiter_if.sv | 27 ++
 rtl/ram64_arbiter_rr_arb2.sv | 21 ++
 rtl/ram64_arbiter.sv | 112 +++++++++++
 tb/tb_ram64_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram64_arbiter_pkg.sv
// Shared constants and types for the RAM64 two-port arbiter/sequencer.
package ram64_ctrl_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;
  typedef enum logic {REQ_A, REQ_B} req_id_t;

  typedef struct packed {
    req_id_t             id;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } cmd_t;
endpackage

// File: rtl/ram64_arbiter_if.sv
// Client-side req/ack bus for both requesters of the RAM64 arbiter.
interface ram64_arbiter_if;
  import ram64_ctrl_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_ack, a_rdata, b_ack, b_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_ack, a_rdata, b_ack, b_rdata
  );
endinterface

// File: rtl/ram64_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the side that was
// not granted last time wins.
module rr_arb2
  import ram64_ctrl_pkg::*;
(
  input  logic    a_req,
  input  logic    b_req,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);
  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = REQ_A;
    if (a_req && b_req) begin
      grant_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (b_req) begin
      grant_id = REQ_B;
    end
  end
endmodule

// File: rtl/ram64_arbiter.sv
// Shares one RAM64 between two req/ack clients with round-robin priority and
// zero-fills the memory after reset.
module ram64_arbiter
  import ram64_ctrl_pkg::*;
#(
  parameter int              INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  ram64_arbiter_if.slave    cli,
  output logic              busy,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  req_id_t           last_grant_reg, last_grant_next;
  cmd_t              cmd_reg, cmd_next;
  logic [DATA_W-1:0] a_rdata_reg, a_rdata_next;
  logic [DATA_W-1:0] b_rdata_reg, b_rdata_next;
  logic              grant_valid;
  req_id_t           grant_id;

  rr_arb2 u_arb (
    .a_req       (cli.a_req),
    .b_req       (cli.b_req),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= (INIT_ON_RESET != 0) ? INIT : IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= REQ_B;
      cmd_reg        <= '0;
      a_rdata_reg    <= '0;
      b_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      cmd_reg        <= cmd_next;
      a_rdata_reg    <= a_rdata_next;
      b_rdata_reg    <= b_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    cmd_next        = cmd_reg;
    a_rdata_next    = a_rdata_reg;
    b_rdata_next    = b_rdata_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(DEPTH - 1)) state_next = IDLE;
      end
      IDLE: begin
        if (grant_valid) begin
          cmd_next.id     = grant_id;
          cmd_next.we     = (grant_id == REQ_A) ? cli.a_we    : cli.b_we;
          cmd_next.addr   = (grant_id == REQ_A) ? cli.a_addr  : cli.b_addr;
          cmd_next.wdata  = (grant_id == REQ_A) ? cli.a_wdata : cli.b_wdata;
          last_grant_next = grant_id;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        // Sampled on the same edge the write lands, so a write returns the old word.
        if (cmd_reg.id == REQ_A) a_rdata_next = ram_out;
        else                     b_rdata_next = ram_out;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM drive is decoded from registers only; load is qualified by rst_n so a
  // write whose edge coincides with reset never reaches the array.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    case (state_reg)
      INIT: begin
        ram_address = cnt_reg;
        ram_in      = rst_n ? INIT_VALUE : '0;
        ram_load    = rst_n;
      end
      ACCESS: begin
        ram_address = cmd_reg.addr;
        ram_in      = cmd_reg.wdata;
        ram_load    = cmd_reg.we & rst_n;
      end
      default: ;
    endcase
  end

  assign busy        = (state_reg == INIT);
  assign cli.a_ack   = (state_reg == RESP) && (cmd_reg.id == REQ_A);
  assign cli.b_ack   = (state_reg == RESP) && (cmd_reg.id == REQ_B);
  assign cli.a_rdata = a_rdata_reg;
  assign cli.b_rdata = b_rdata_reg;
endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: RAM64 behavioural array, a timeline-based model
// checked every cycle, and directed client transactions with literal checks.
module tb_ram64_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [5:0]  ram_address;
  logic [15:0] ram_out;
  logic [15:0] mem [64];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  ram64_arbiter_if cif ();

  ram64_arbiter #(.INIT_ON_RESET(1), .INIT_VALUE(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cli         (cif),
    .busy        (busy),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One client transaction: raise req, wait for ack, then drop req next cycle.
  task automatic xact(input bit port, input bit we, input logic [5:0] addr,
                      input logic [15:0] wdata, output logic [15:0] rdata, output int ack_cyc);
    int  n;
    bit  got;
    if (!port) begin
      cif.a_we = we; cif.a_addr = addr; cif.a_wdata = wdata; cif.a_req = 1'b1;
    end else begin
      cif.b_we = we; cif.b_addr = addr; cif.b_wdata = wdata; cif.b_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if ((!port && cif.a_ack) || (port && cif.b_ack)) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout port=%0d got=no_ack want=ack", port);
    end
    rdata   = port ? cif.b_rdata : cif.a_rdata;
    ack_cyc = cyc;
    $display("[TB] cyc=%0d port=%s we=%0d addr=%0d wdata=%h rdata=%h", cyc,
             port ? "B" : "A", we, addr, wdata, rdata);
    @(posedge clk); #1;
    if (!port) cif.a_req = 1'b0;
    else       cif.b_req = 1'b0;
  endtask

  // Timeline model: sweep index, then scheduled access/ack cycles per grant.
  initial begin
    int          si, free_at, acc_cyc, ack_cyc;
    bit          m_id, m_last, sweeping, exp_load, exp_aa, exp_ab;
    logic        m_we;
    logic [5:0]  m_addr;
    logic [15:0] m_wd, m_ra, m_rb;
    logic [15:0] shadow [64];
    si = 0; free_at = 1 << 30; acc_cyc = -1; ack_cyc = -1;
    m_last = 1'b1; m_ra = '0; m_rb = '0; m_id = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wd = '0;
    forever begin
      @(negedge clk);
      sweeping = (si < 64);
      exp_load = 1'b0; exp_aa = 1'b0; exp_ab = 1'b0;
      chk("busy", 32'(busy), 32'(sweeping));
      if (sweeping) begin
        exp_load = rst_n;
        chk("sweep_addr", 32'(ram_address), si);
        if (rst_n) chk("sweep_data", 32'(ram_in), 32'h0);
      end
      if (cyc == acc_cyc) begin
        exp_load = m_we && rst_n;
        chk("acc_addr", 32'(ram_address), 32'(m_addr));
        if (m_we) chk("acc_wdata", 32'(ram_in), 32'(m_wd));
      end
      if (cyc == ack_cyc) begin
        exp_aa = !m_id;
        exp_ab = m_id;
      end
      chk("ram_load", 32'(ram_load), 32'(exp_load));
      chk("a_ack", 32'(cif.a_ack), 32'(exp_aa));
      chk("b_ack", 32'(cif.b_ack), 32'(exp_ab));
      chk("a_rdata", 32'(cif.a_rdata), 32'(m_ra));
      chk("b_rdata", 32'(cif.b_rdata), 32'(m_rb));
      if (!rst_n) begin
        si = 0; acc_cyc = -1; ack_cyc = -1; free_at = 1 << 30;
        m_last = 1'b1; m_ra = '0; m_rb = '0;
      end else begin
        if (sweeping) begin
          shadow[si[5:0]] = 16'h0000;
          si++;
          if (si == 64) free_at = cyc + 1;
        end
        if (cyc == acc_cyc) begin
          if (m_id) m_rb = shadow[m_addr];
          else      m_ra = shadow[m_addr];
          if (m_we) shadow[m_addr] = m_wd;
        end
        if (!sweeping && cyc >= free_at && (cif.a_req || cif.b_req)) begin
          m_id   = (cif.a_req && cif.b_req) ? !m_last : cif.b_req;
          m_we   = m_id ? cif.b_we    : cif.a_we;
          m_addr = m_id ? cif.b_addr  : cif.a_addr;
          m_wd   = m_id ? cif.b_wdata : cif.a_wdata;
          m_last = m_id;
          acc_cyc = cyc + 1; ack_cyc = cyc + 2; free_at = cyc + 3;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd_a, rd_a2, rd_b, rd_b2;
    int          ca, ca2, cb, cb2, n, idle_cyc, t0;
    rst_n = 1'b0;
    cif.a_req = 0; cif.a_we = 0; cif.a_addr = '0; cif.a_wdata = '0;
    cif.b_req = 0; cif.b_we = 0; cif.b_addr = '0; cif.b_wdata = '0;
    idle_cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sweep, then contention on the first IDLE and continuous alternation.
    fork
      begin
        n = 0;
        while (busy && n < 200) begin n++; @(posedge clk); #1; end
        idle_cyc = cyc;
        chk("busy_len", n, 64);
      end
      begin
        repeat (8) @(posedge clk); #1;
        xact(1'b0, 1'b0, 6'd0, 16'h0, rd_a, ca);
        xact(1'b0, 1'b1, 6'd20, 16'h1111, rd_a2, ca2);
      end
      begin
        repeat (8) @(posedge clk); #1;
        xact(1'b1, 1'b0, 6'd31, 16'h0, rd_b, cb);
        xact(1'b1, 1'b0, 6'd20, 16'h0, rd_b2, cb2);
      end
    join
    chk("rd_addr0", 32'(rd_a), 32'h0);
    chk("rd_addr31", 32'(rd_b), 32'h0);
    chk("ack1_A", ca, idle_cyc + 2);
    chk("ack2_B", cb, idle_cyc + 5);
    chk("ack3_A", ca2, idle_cyc + 8);
    chk("ack4_B", cb2, idle_cyc + 11);
    chk("b_rd20", 32'(rd_b2), 32'h1111);

    xact(1'b0, 1'b0, 6'd63, 16'h0, rd_a, ca);
    chk("rd_addr63", 32'(rd_a), 32'h0);

    t0 = cyc;
    xact(1'b0, 1'b1, 6'd5, 16'hBEEF, rd_a, ca);
    chk("wr5_old", 32'(rd_a), 32'h0);
    chk("wr5_lat", ca, t0 + 2);
    xact(1'b0, 1'b0, 6'd5, 16'h0, rd_a, ca);
    chk("rd5_a", 32'(rd_a), 32'hBEEF);
    xact(1'b1, 1'b0, 6'd5, 16'h0, rd_b, cb);
    chk("rd5_b", 32'(rd_b), 32'hBEEF);

    fork
      xact(1'b0, 1'b1, 6'd63, 16'h1234, rd_a, ca);
      xact(1'b1, 1'b0, 6'd63, 16'h0, rd_b, cb);
    join
    chk("coh_a_old", 32'(rd_a), 32'h0);
    chk("coh_b", 32'(rd_b), 32'h1234);
    chk("coh_order", cb, ca + 3);

    // Reset lands during A's ACCESS of a write to addr 7.
    t0 = cyc;
    cif.a_we = 1'b1; cif.a_addr = 6'd7; cif.a_wdata = 16'hAAAA; cif.a_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cif.a_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_noack", 32'(cif.a_ack), 32'h0);
    chk("abort_busy", 32'(busy), 32'h1);
    $display("[TB] cyc=%0d reset during access started at cyc=%0d", cyc, t0);

    fork
      begin
        n = 0;
        while (busy && n < 200) begin n++; @(posedge clk); #1; end
        idle_cyc = cyc;
        chk("busy_len2", n, 64);
      end
      begin
        repeat (2) @(posedge clk); #1;
        xact(1'b1, 1'b0, 6'd10, 16'h0, rd_b, cb);
      end
    join
    chk("init_req_lat", cb, idle_cyc + 2);
    chk("init_req_rd", 32'(rd_b), 32'h0);
    xact(1'b0, 1'b0, 6'd7, 16'h0, rd_a, ca);
    chk("rd7_after_abort", 32'(rd_a), 32'h0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
